// File: rtl/stage_ex_md_if.sv
// ID/EX operand bundle into the execute stage.
// Carries the EX result, store data and stall request back out.
interface stage_ex_md_if #(
  parameter int W = 32
);
  logic         ex_valid;
  logic         flush;
  logic [1:0]   forwardA;
  logic [1:0]   forwardB;
  logic [W-1:0] ID_EX_data_out_1;
  logic [W-1:0] ID_EX_data_out_2;
  logic [W-1:0] ID_EX_imm_out;
  logic [W-1:0] ID_EX_pc;
  logic [W-1:0] WB_data;
  logic [W-1:0] EX_MEM_alu_out;
  logic [2:0]   ID_EX_alu_sel;
  logic         ID_EX_ASel;
  logic         ID_EX_BSel;
  logic         ID_EX_md_en;
  logic [2:0]   ID_EX_md_op;
  logic [W-1:0] ex_out;
  logic [W-1:0] dataB;
  logic         ex_stall;

  modport master (
    output ex_valid, flush, forwardA, forwardB,
    output ID_EX_data_out_1, ID_EX_data_out_2,
    output ID_EX_imm_out, ID_EX_pc,
    output WB_data, EX_MEM_alu_out,
    output ID_EX_alu_sel, ID_EX_ASel, ID_EX_BSel,
    output ID_EX_md_en, ID_EX_md_op,
    input  ex_out, dataB, ex_stall
  );

  modport slave (
    input  ex_valid, flush, forwardA, forwardB,
    input  ID_EX_data_out_1, ID_EX_data_out_2,
    input  ID_EX_imm_out, ID_EX_pc,
    input  WB_data, EX_MEM_alu_out,
    input  ID_EX_alu_sel, ID_EX_ASel, ID_EX_BSel,
    input  ID_EX_md_en, ID_EX_md_op,
    output ex_out, dataB, ex_stall
  );
endinterface

// File: rtl/stage_ex_md.sv
// Execute stage: operand forwarding, single-cycle ALU and a
// sequential RV32M multiply/divide unit that stalls the pipeline.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   sel_i,
  output logic [W-1:0] y_o
);
  localparam int SW = $clog2(W);

  logic [SW-1:0] sh;
  assign sh = b_i[SW-1:0];

  always_comb begin
    y_o = '0;
    unique case (sel_i)
      3'd0: y_o = a_i + b_i;
      3'd1: y_o = a_i - b_i;
      3'd2: y_o = a_i & b_i;
      3'd3: y_o = a_i | b_i;
      3'd4: y_o = a_i ^ b_i;
      3'd5: y_o = a_i << sh;
      3'd6: y_o = a_i >> sh;
      3'd7: y_o = $signed(a_i) >>> sh;
    endcase
  end
endmodule

module stage_ex_md #(
  parameter int REG_WIDTH = `REG_WIDTH,
  parameter int MD_ENABLE = 1
) (
  input logic          clk,
  input logic          reset_n,
  stage_ex_md_if.slave bus
);
  localparam int N  = REG_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam bit MDE = (MD_ENABLE != 0);
  localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  opd_q, opd_d;
  logic [N-1:0]  res_q, res_d;
  logic [2:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0] fwd_a, fwd_b;
  logic [N-1:0] alu_a, alu_b, alu_y;

  always_comb begin
    fwd_a = '0;
    unique case (bus.forwardA)
      2'b00:   fwd_a = bus.ID_EX_data_out_1;
      2'b01:   fwd_a = bus.WB_data;
      2'b10:   fwd_a = bus.EX_MEM_alu_out;
      default: fwd_a = '0;
    endcase
  end

  always_comb begin
    fwd_b = '0;
    unique case (bus.forwardB)
      2'b00:   fwd_b = bus.ID_EX_data_out_2;
      2'b01:   fwd_b = bus.WB_data;
      2'b10:   fwd_b = bus.EX_MEM_alu_out;
      default: fwd_b = '0;
    endcase
  end

  assign alu_a = bus.ID_EX_ASel ? bus.ID_EX_pc : fwd_a;
  assign alu_b = bus.ID_EX_BSel ? bus.ID_EX_imm_out : fwd_b;

  alu #(.W(N)) u_alu (
    .a_i   (alu_a),
    .b_i   (alu_b),
    .sel_i (bus.ID_EX_alu_sel),
    .y_o   (alu_y)
  );

  logic [2:0]   md_op;
  logic         issue, is_div, sgn_a, sgn_b;
  logic         div_zero, div_ovf;
  logic [N-1:0] mag_a, mag_b;

  assign md_op = bus.ID_EX_md_op;
  assign issue = MDE & bus.ex_valid & bus.ID_EX_md_en
               & (state_q == IDLE) & ~bus.flush;
  assign is_div = md_op[2];
  // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
  assign sgn_a = fwd_a[N-1] & (md_op == 3'd1 | md_op == 3'd2
                             | md_op == 3'd4 | md_op == 3'd6);
  assign sgn_b = fwd_b[N-1] & (md_op == 3'd1 | md_op == 3'd4
                             | md_op == 3'd6);
  assign mag_a = sgn_a ? -fwd_a : fwd_a;
  assign mag_b = sgn_b ? -fwd_b : fwd_b;
  assign div_zero = is_div & (fwd_b == '0);
  assign div_ovf = is_div & ~md_op[0] & (fwd_a == MIN) & (&fwd_b);

  logic [N:0]     sum, shl, diff;
  logic [N-1:0]   acc_nx, lo_nx, quo, rem, fin;
  logic [2*N-1:0] prod;

  always_comb begin
    sum  = {1'b0, acc_q} + {1'b0, {N{lo_q[0]}} & opd_q};
    shl  = {acc_q, lo_q[N-1]};
    diff = shl - {1'b0, opd_q};
    if (op_q[2]) begin
      // restoring divide: remainder in acc, quotient shifts into lo
      if (diff[N]) begin
        acc_nx = shl[N-1:0];
        lo_nx  = {lo_q[N-2:0], 1'b0};
      end else begin
        acc_nx = diff[N-1:0];
        lo_nx  = {lo_q[N-2:0], 1'b1};
      end
    end else begin
      acc_nx = sum[N:1];
      lo_nx  = {sum[0], lo_q[N-1:1]};
    end
    prod = {acc_nx, lo_nx};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo_nx : lo_nx;
    rem = neg_q ? -acc_nx : acc_nx;
    fin = '0;
    unique case (1'b1)
      op_q == 3'd0:                fin = prod[N-1:0];
      !op_q[2] && op_q != 3'd0:    fin = prod[2*N-1:N];
      op_q[2] && !op_q[1]:         fin = quo;
      op_q[2] && op_q[1]:          fin = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opd_d   = opd_q;
    res_d   = res_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          op_d    = md_op;
          neg_d   = (md_op == 3'd6) ? sgn_a : (sgn_a ^ sgn_b);
          acc_d   = '0;
          lo_d    = is_div ? mag_a : mag_b;
          opd_d   = is_div ? mag_b : mag_a;
          cnt_d   = CW'(N);
          state_d = CALC;
          if (div_zero) begin
            res_d   = md_op[1] ? fwd_a : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = md_op[1] ? '0 : fwd_a;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        acc_d = acc_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = fin;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      lo_q    <= '0;
      opd_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opd_q   <= opd_d;
      res_q   <= res_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dataB = fwd_b;
  assign bus.ex_out = (state_q == DONE && !bus.flush) ? res_q : alu_y;
  assign bus.ex_stall = reset_n
    & (issue | ((state_q == CALC) & ~bus.flush));
endmodule
